// File: rtl/pc_fetch_if.sv
// Signal bundle between the PC fetch controller and its environment
// (instruction memory, datapath redirect sources and run/halt control).
interface pc_fetch_if;
  logic        run;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        busy;
  logic        fault;

  modport master (
    input  run, halt_req, imem_ready, imem_rdata,
           branch_taken, branch_offset, jump, jump_target, jr, jr_target,
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
           pc, pc_next, busy, fault
  );

  modport slave (
    output run, halt_req, imem_ready, imem_rdata,
           branch_taken, branch_offset, jump, jump_target, jr, jr_target,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
           pc, pc_next, busy, fault
  );
endinterface

// File: rtl/pc_fetch_controller.sv
// Program-counter sequencer: FETCH with ready handshake and wait timeout,
// one-cycle EXEC with next-PC selection, run/halt control and sticky faults.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input logic         clk,
  input logic         reset,
  pc_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [7:0]  wait_q, wait_d;
  logic        halt_pend_q, halt_pend_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  // Redirect priority: jr over jump over branch over sequential.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    if (bus.jr)                redirect_pc = bus.jr_target;
    else if (bus.jump)         redirect_pc = {pc_plus4[31:28], bus.jump_target, 2'b00};
    else if (bus.branch_taken) redirect_pc = pc_plus4 + (bus.branch_offset << 2);
    else                       redirect_pc = pc_plus4;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    wait_d      = wait_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH;

      S_FETCH: begin
        if (bus.halt_req) halt_pend_d = 1'b1;
        if (bus.imem_ready) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          wait_d     = 8'd0;
          state_d    = S_EXEC;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == WAIT_LIMIT) state_d = S_FAULT;
        end
      end

      S_EXEC: begin
        // A misaligned target faults without committing the new PC.
        if (redirect_pc[1:0] != 2'b00) begin
          state_d = S_FAULT;
        end else begin
          pc_d = redirect_pc;
          if (bus.halt_req || halt_pend_q) begin
            state_d     = S_HALTED;
            halt_pend_d = 1'b0;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_HALTED: if (bus.run) state_d = S_FETCH;

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= 32'd0;
      instr_pc_q  <= 32'd0;
      wait_q      <= 8'd0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == S_EXEC);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_next     = (state_q == S_EXEC) ? redirect_pc : pc_q;
  assign bus.busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign bus.fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_pc_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 16;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  pc_fetch_if bus ();

  pc_fetch_controller #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_FETCH, M_EXEC, M_HALTED, M_FAULT} mode_t;

  mode_t       m_mode    = M_IDLE;
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_instr   = 0;
  logic [31:0] m_ipc     = 0;
  int          m_wait    = 0;
  bit          m_halt_pd = 0;

  function automatic logic [31:0] model_target();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (bus.jr)           return bus.jr_target;
    if (bus.jump)         return {seq[31:28], bus.jump_target, 2'b00};
    if (bus.branch_taken) return seq + bus.branch_offset * 32'd4;
    return seq;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_pc = RESET_PC; m_instr = 0; m_ipc = 0;
      m_wait = 0; m_halt_pd = 0;
    end else begin
      case (m_mode)
        M_IDLE:   if (bus.run) m_mode = M_FETCH;
        M_HALTED: if (bus.run) m_mode = M_FETCH;
        M_FETCH: begin
          if (bus.halt_req) m_halt_pd = 1;
          if (bus.imem_ready) begin
            m_instr = bus.imem_rdata; m_ipc = m_pc; m_wait = 0; m_mode = M_EXEC;
          end else begin
            m_wait++;
            if (m_wait == MAX_WAIT) m_mode = M_FAULT;
          end
        end
        M_EXEC: begin
          logic [31:0] t;
          t = model_target();
          if (t % 4 != 0) m_mode = M_FAULT;
          else begin
            m_pc = t;
            if (bus.halt_req || m_halt_pd) begin m_mode = M_HALTED; m_halt_pd = 0; end
            else m_mode = M_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    check("imem_req",    32'(bus.imem_req),    32'(m_mode == M_FETCH));
    check("imem_addr",   bus.imem_addr,        m_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(m_mode == M_EXEC));
    check("instr",       bus.instr,            m_instr);
    check("instr_pc",    bus.instr_pc,         m_ipc);
    check("pc",          bus.pc,               m_pc);
    check("pc_next",     bus.pc_next,          (m_mode == M_EXEC) ? model_target() : m_pc);
    check("busy",        32'(bus.busy),        32'(m_mode == M_FETCH || m_mode == M_EXEC));
    check("fault",       32'(bus.fault),       32'(m_mode == M_FAULT));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    bus.imem_rdata = $urandom();
  endtask

  task automatic clear_inputs();
    bus.run = 0; bus.halt_req = 0; bus.imem_ready = 0; bus.imem_rdata = 0;
    bus.branch_taken = 0; bus.branch_offset = 0; bus.jump = 0;
    bus.jump_target = 0; bus.jr = 0; bus.jr_target = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic to_exec();
    int n = 0;
    while (m_mode != M_EXEC && n < 64) begin
      tick();
      n++;
    end
    check("exec_reached", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic start_run();
    bus.run = 1;
    bus.imem_ready = 1;
    tick();
    bus.run = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_inputs();
    #2;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_pc",       bus.pc,            RESET_PC);
    do_reset();

    // 1: sequential fetch with zero wait states
    start_run();
    for (int k = 0; k < 4; k++) begin
      to_exec();
      check("t1_instr_pc", bus.instr_pc, 32'(k * 4));
      check("t1_busy_exec", 32'(bus.busy), 32'd1);
      tick();
      check("t1_valid_gap", 32'(bus.instr_valid), 32'd0);
      check("t1_busy_fetch", 32'(bus.busy), 32'd1);
    end

    // 2: branch, jump, and combined redirect
    do_reset();
    start_run();
    for (int k = 0; k < 2; k++) begin to_exec(); tick(); end
    to_exec();
    check("t2_at_8", bus.instr_pc, 32'h8);
    bus.branch_taken = 1; bus.branch_offset = 32'hFFFF_FFFE;
    #1 check("t2_br_pc_next", bus.pc_next, 32'h4);
    tick();
    bus.branch_taken = 0;
    check("t2_br_addr", bus.imem_addr, 32'h4);
    for (int k = 0; k < 3; k++) begin to_exec(); tick(); end
    to_exec();
    check("t2_at_10", bus.instr_pc, 32'h10);
    bus.jump = 1; bus.jump_target = 26'h40;
    tick();
    bus.jump = 0;
    check("t2_j_addr", bus.imem_addr, 32'h100);
    to_exec();
    bus.jr = 1; bus.jump = 1; bus.branch_taken = 1;
    bus.jr_target = 32'h200; bus.jump_target = 26'h3FF_FFFF; bus.branch_offset = 32'd5;
    tick();
    bus.jr = 0; bus.jump = 0; bus.branch_taken = 0;
    check("t2_prio_addr", bus.imem_addr, 32'h200);

    // 3: misaligned jr target faults and stays faulted
    to_exec();
    bus.jr = 1; bus.jr_target = 32'h202;
    tick();
    bus.jr = 0;
    check("t3_fault", 32'(bus.fault), 32'd1);
    check("t3_pc_held", bus.pc, 32'h200);
    for (int k = 0; k < 4; k++) begin
      bus.run = 1;
      tick();
      check("t3_req_low", 32'(bus.imem_req), 32'd0);
    end
    bus.run = 0;

    // 4: wait states, then timeout
    do_reset();
    bus.run = 1;
    tick();
    bus.run = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_wait_req", 32'(bus.imem_req), 32'd1);
    end
    bus.imem_ready = 1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ready = 0;
    check("t4_exec", 32'(bus.instr_valid), 32'd1);
    check("t4_instr", bus.instr, 32'hDEAD_BEEF);
    tick();
    for (int k = 0; k < MAX_WAIT - 1; k++) tick();
    check("t4_no_fault_yet", 32'(bus.fault), 32'd0);
    tick();
    check("t4_timeout_fault", 32'(bus.fault), 32'd1);

    // 5: halt pulse during FETCH, then resume
    do_reset();
    start_run();
    to_exec();
    tick();
    bus.halt_req = 1;
    check("t5_fetch_4", bus.imem_addr, 32'h4);
    tick();
    bus.halt_req = 0;
    check("t5_exec_4", bus.instr_pc, 32'h4);
    tick();
    check("t5_halt_pc", bus.pc, 32'h8);
    check("t5_halt_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    check("t5_still_halted", 32'(bus.imem_req), 32'd0);
    bus.run = 1;
    tick();
    bus.run = 0;
    bus.imem_ready = 0;
    check("t5_resume_req", 32'(bus.imem_req), 32'd1);
    check("t5_resume_addr", bus.imem_addr, 32'h8);

    // 6: asynchronous reset mid-fetch
    tick();
    #2 reset = 1;
    #1;
    check("t6_req", 32'(bus.imem_req), 32'd0);
    check("t6_pc", bus.pc, RESET_PC);
    check("t6_busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      bus.run           = ($urandom_range(0, 3) == 0);
      bus.halt_req      = ($urandom_range(0, 15) == 0);
      bus.imem_ready    = ($urandom_range(0, 2) != 0);
      bus.branch_taken  = ($urandom_range(0, 3) == 0);
      bus.branch_offset = 32'($urandom_range(0, 64)) - 32'd32;
      bus.jump          = ($urandom_range(0, 7) == 0);
      bus.jump_target   = 26'($urandom());
      bus.jr            = ($urandom_range(0, 9) == 0);
      r                 = $urandom();
      bus.jr_target     = ($urandom_range(0, 5) == 0) ? r : (r & ~32'h3);
      if (m_mode == M_FAULT || $urandom_range(0, 299) == 0) begin
        reset = 1;
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
